run_display_ctrl: RTL and testbench
===================================

Name: run_display_ctrl

Overview:
Run controller and display scheduler between the board I/O and the RISC-V/filter subsystem. It debounces the start pushbutton and issues a single-cycle start pulse to the core. It tracks the run to completion and snapshots the four 32-bit status words (parameters, a0, filter cycles, core cycles) on done. It selects which word feeds the eight seven-segment decoders, either from switches or by timed auto-rotation.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must be stable before it is accepted.
ROTATE_CYCLES, 100000000, cycles each page is shown in auto-rotate mode.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_raw  in  1  raw start pushbutton, asynchronous to clk
swt_0  in  1  page select bit 0 (manual mode)
swt_1  in  1  page select bit 1 (manual mode)
auto_rotate  in  1  1 = cycle pages on a timer; 0 = switches select the page
done  in  1  core run-complete flag (level, driven by core led0)
parameters  in  32  core parameter word
reg_a0  in  32  core result register a0
filter_clk_counter  in  32  filter cycle count
clk_counter  in  32  core cycle count
start_pulse  out  1  one-cycle start request to the core
busy  out  1  1 while a run is in flight
page  out  2  currently displayed page index
ss_value  out  32  word sent to the seven-segment decoders (nibble i -> digit i)

Behaviour:
- Reset (async, rst=1): FSM=IDLE; start_pulse=0; busy=0; page=0; ss_value=0; snapshot regs=0; debounced level=0; all counters=0.
- Button path: 2-FF synchronizer, then debounce. The counter clears on any change of the synchronized level. The accepted level updates once the level has been stable for DEBOUNCE_CYCLES consecutive cycles. press = one-cycle pulse on rising edge of the accepted level. Releases generate nothing.
- done is registered once (done_q). done_rise = done & ~done_q.
- FSM states: IDLE, START, RUN, DONE.
  IDLE: press -> START.
  START: start_pulse=1 for exactly this one cycle -> RUN.
  RUN: busy=1. press ignored. done_rise -> latch all four input words into snapshot in that cycle -> DONE. done already high on RUN entry is not completion; a rising edge is required.
  DONE: busy=0. press -> START. The snapshot is held until the next completion overwrites it.
- start_pulse and busy are registered, decoded from the next state, so start_pulse is high in the START-state cycle.
- Page mapping: 0 clk_counter, 1 filter_clk_counter, 2 reg_a0, 3 parameters.
- Manual mode (auto_rotate=0): page={swt_1,swt_0}, registered with 1-cycle latency.
- Auto mode (auto_rotate=1):
  Rotate counter counts 0..ROTATE_CYCLES-1. On terminal count, page increments mod 4 (3 -> 0).
  Rising edge of auto_rotate clears the rotate counter and starts from the current page.
  Falling edge returns to switch page on the next cycle.
- Source select: in DONE, ss_value = snapshot[page]; in IDLE/START/RUN, ss_value = live input[page]. ss_value is registered, 1 cycle after page/state.
- Simultaneous events:
  press and done_rise in the same RUN cycle: completion wins, press dropped.
  Rotate terminal count and auto_rotate falling edge in the same cycle: manual page wins.
- Reset mid-run: returns to IDLE immediately. No start_pulse is generated after reset release without a fresh accepted press.
- Counter widths are $clog2 of the parameter; no overflow beyond terminal count.

Decomposition:
- Shared package run_ctrl_pkg holds:
  FSM state enum (IDLE=0, START=1, RUN=2, DONE=3);
  page constants (PG_CLK=0, PG_FILT=1, PG_A0=2, PG_PARAM=3);
  status word width = 32.
- One sub-module, btn_debounce: synchronizer, debounce counter and rising-edge press output, parameterized by DEBOUNCE_CYCLES. Reused for any future board buttons.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, ROTATE_CYCLES=8.
1. Bouncy button (btn_raw toggling every 2 cycles for 10 cycles, then held high 10 cycles) -> exactly one press and one start_pulse, width 1; busy=1 from the following cycle.
2. Run in RUN: done low->high while reg_a0=0x0000002A and clk_counter=0x1234 -> state DONE, busy=0. With swt={1,0}, ss_value=0x0000002A. Inputs then changed -> ss_value unchanged.
3. Press held while in RUN; done stays high from the previous run -> no completion and no extra start_pulse until done falls and rises again.
4. auto_rotate=1 from page 2 -> page 3,0,1 at 8-cycle intervals (wrap checked). auto_rotate=0 with swt={0,1} -> page=1 next cycle.
5. Press in DONE -> new start_pulse. The old snapshot stays displayed only until RUN entry, then the live value is shown. New done_rise overwrites the snapshot.
6. rst asserted asynchronously mid-RUN (between clk edges) -> busy=0, ss_value=0, page=0 immediately. No start_pulse after rst deassert with button idle.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and constants for the run/display controller
package run_ctrl_pkg;

    localparam int STATUS_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    localparam logic [1:0] PG_CLK   = 2'd0;
    localparam logic [1:0] PG_FILT  = 2'd1;
    localparam logic [1:0] PG_A0    = 2'd2;
    localparam logic [1:0] PG_PARAM = 2'd3;

    // Maps a page index onto one of the four status words.
    function automatic logic [STATUS_W-1:0] page_word(
        input logic [1:0]          pg,
        input logic [STATUS_W-1:0] w_clk,
        input logic [STATUS_W-1:0] w_filt,
        input logic [STATUS_W-1:0] w_a0,
        input logic [STATUS_W-1:0] w_param
    );
        logic [STATUS_W-1:0] w;
        case (pg)
            PG_CLK:  w = w_clk;
            PG_FILT: w = w_filt;
            PG_A0:   w = w_a0;
            default: w = w_param;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debouncer and press-edge detector
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   btn_raw   - raw button level, asynchronous to clk
//   press     - one-cycle pulse when the accepted level rises
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles in which the synchronized level differs
    // from the accepted one; returning to the accepted level clears it, so
    // any bounce restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                cnt   <= '0;
                level <= sync_2;
                press <= sync_2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/run_display_ctrl.sv
// rtl/run_display_ctrl.sv - run controller and seven-segment page scheduler
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   btn_raw                  - raw start button
//   swt_0, swt_1             - manual page select
//   auto_rotate              - 1 = timed page rotation
//   done                     - core run-complete level
//   parameters, reg_a0,
//   filter_clk_counter,
//   clk_counter              - live status words
//   start_pulse              - one-cycle start request
//   busy                     - run in flight
//   page                     - displayed page index
//   ss_value                 - word driven to the digit decoders
module run_display_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ROTATE_CYCLES   = 100000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_raw,
    input  logic                swt_0,
    input  logic                swt_1,
    input  logic                auto_rotate,
    input  logic                done,
    input  logic [STATUS_W-1:0] parameters,
    input  logic [STATUS_W-1:0] reg_a0,
    input  logic [STATUS_W-1:0] filter_clk_counter,
    input  logic [STATUS_W-1:0] clk_counter,
    output logic                start_pulse,
    output logic                busy,
    output logic [1:0]          page,
    output logic [STATUS_W-1:0] ss_value
);

    localparam int RW = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;
    localparam logic [RW-1:0] ROT_TERM = RW'(ROTATE_CYCLES - 1);

    run_state_t          state;
    run_state_t          state_next;
    logic                press;
    logic                done_q;
    logic                done_rise;
    logic                auto_q;
    logic [RW-1:0]       rot_cnt;
    logic [STATUS_W-1:0] snap [4];

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .press   (press)
    );

    assign done_rise = done & ~done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            start_pulse <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            done_q      <= done;
            start_pulse <= (state_next == START);
            busy        <= (state_next == RUN);
        end
    end

    // Press is simply not looked at in RUN, so a press coinciding with
    // completion is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press) state_next = START;
            START:   state_next = RUN;
            RUN:     if (done_rise) state_next = DONE;
            DONE:    if (press) state_next = START;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) snap[i] <= '0;
        end else if (state == RUN && done_rise) begin
            snap[PG_CLK]   <= clk_counter;
            snap[PG_FILT]  <= filter_clk_counter;
            snap[PG_A0]    <= reg_a0;
            snap[PG_PARAM] <= parameters;
        end
    end

    // Manual mode is tested first, so a falling auto_rotate always wins over
    // a rotate terminal count in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_q  <= 1'b0;
            rot_cnt <= '0;
            page    <= PG_CLK;
        end else begin
            auto_q <= auto_rotate;
            if (!auto_rotate) begin
                page    <= {swt_1, swt_0};
                rot_cnt <= '0;
            end else if (!auto_q) begin
                rot_cnt <= '0;
            end else if (rot_cnt == ROT_TERM) begin
                rot_cnt <= '0;
                page    <= page + 2'd1;
            end else begin
                rot_cnt <= rot_cnt + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_value <= '0;
        end else if (state == DONE) begin
            ss_value <= snap[page];
        end else begin
            ss_value <= page_word(page, clk_counter, filter_clk_counter,
                                  reg_a0, parameters);
        end
    end

endmodule

// File: tb/tb_run_display_ctrl.sv
// tb/tb_run_display_ctrl.sv - self-checking bench for run_display_ctrl
module tb_run_display_ctrl;

    localparam int DB  = 4;
    localparam int ROT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_raw = 1'b0;
    logic        swt_0 = 1'b0;
    logic        swt_1 = 1'b0;
    logic        auto_rotate = 1'b0;
    logic        done = 1'b0;
    logic [31:0] parameters = 32'h0;
    logic [31:0] reg_a0 = 32'h0;
    logic [31:0] filter_clk_counter = 32'h0;
    logic [31:0] clk_counter = 32'h0;
    logic        start_pulse;
    logic        busy;
    logic [1:0]  page;
    logic [31:0] ss_value;

    int n_checks = 0;
    int n_errors = 0;
    int sp_count = 0;
    bit checking = 1'b0;

    run_display_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .ROTATE_CYCLES  (ROT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .btn_raw           (btn_raw),
        .swt_0             (swt_0),
        .swt_1             (swt_1),
        .auto_rotate       (auto_rotate),
        .done              (done),
        .parameters        (parameters),
        .reg_a0            (reg_a0),
        .filter_clk_counter(filter_clk_counter),
        .clk_counter       (clk_counter),
        .start_pulse       (start_pulse),
        .busy              (busy),
        .page              (page),
        .ss_value          (ss_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the button history array holds past samples of
    // btn_raw (h[k] = sample taken k+1 edges ago before the shift); the
    // synchronizer delays by two edges, and a level is accepted once the
    // last DB synchronized samples all disagree with it.
    logic        h [0:DB];
    logic        m_level, m_press, m_done_p, m_auto_p;
    int          m_mode;            // 0 idle, 1 start, 2 run, 3 done
    logic        m_sp, m_busy;
    int          m_page;
    logic [31:0] m_ss;
    logic [31:0] m_snap [4];
    longint      m_edge, m_n0;
    logic        t_diff, t_rise;
    int          t_mode, t_page;

    function automatic logic [31:0] live_word(input int pg);
        case (pg)
            0: return clk_counter;
            1: return filter_clk_counter;
            2: return reg_a0;
            default: return parameters;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= DB; k++) h[k] = 1'b0;
            m_level = 0; m_press = 0; m_done_p = 0; m_auto_p = 0;
            m_mode = 0; m_sp = 0; m_busy = 0; m_page = 0; m_ss = 0;
            for (int k = 0; k < 4; k++) m_snap[k] = 0;
            m_edge = 0; m_n0 = 0;
        end else begin
            t_diff = 1'b1;
            for (int k = 1; k <= DB; k++) if (h[k] == m_level) t_diff = 1'b0;
            t_rise = done && !m_done_p;

            m_ss = (m_mode == 3) ? m_snap[m_page] : live_word(m_page);

            t_mode = m_mode;
            case (m_mode)
                0: if (m_press) t_mode = 1;
                1: t_mode = 2;
                2: if (t_rise) begin
                       t_mode = 3;
                       for (int k = 0; k < 4; k++) m_snap[k] = live_word(k);
                   end
                default: if (m_press) t_mode = 1;
            endcase
            m_mode = t_mode;
            m_sp   = (t_mode == 1);
            m_busy = (t_mode == 2);

            if (!auto_rotate) t_page = {30'b0, swt_1, swt_0};
            else if (!m_auto_p) begin t_page = m_page; m_n0 = m_edge; end
            else if ((m_edge - m_n0) % ROT == 0) t_page = (m_page + 1) % 4;
            else t_page = m_page;
            m_page = t_page;

            m_press = t_diff && !m_level;
            if (t_diff) m_level = !m_level;
            for (int k = DB; k > 0; k--) h[k] = h[k-1];
            h[0] = btn_raw;
            m_done_p = done;
            m_auto_p = auto_rotate;
            m_edge++;
        end
    end

    always @(negedge clk) begin
        if (!rst && checking) begin
            chk("start_pulse", {31'b0, start_pulse}, {31'b0, m_sp});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("page", {30'b0, page}, 32'(m_page));
            chk("ss_value", ss_value, m_ss);
            if (start_pulse) sp_count++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn();
        btn_raw = 1'b1; tick(10);
        btn_raw = 1'b0; tick(10);
    endtask

    int sp0;

    initial begin
        tick(3);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_page", {30'b0, page}, 32'd0);
        chk("reset_ss", ss_value, 32'd0);
        chk("reset_sp", {31'b0, start_pulse}, 32'd0);
        rst = 1'b0;
        checking = 1'b1;
        tick(2);

        // bouncy button: 2-cycle bounces never reach the 4-cycle window
        sp0 = sp_count;
        for (int i = 0; i < 10; i++) begin
            btn_raw = ((i / 2) % 2 == 0);
            tick(1);
        end
        btn_raw = 1'b1; tick(10);
        btn_raw = 1'b0; tick(10);
        chk("bounce_one_start", 32'(sp_count - sp0), 32'd1);
        chk("bounce_busy", {31'b0, busy}, 32'd1);

        // completion snapshots the words
        swt_1 = 1'b1; swt_0 = 1'b0;
        reg_a0 = 32'h0000002A; clk_counter = 32'h1234;
        tick(2);
        done = 1'b1; tick(3);
        chk("done_busy", {31'b0, busy}, 32'd0);
        chk("done_ss_a0", ss_value, 32'h0000002A);
        reg_a0 = 32'h55; clk_counter = 32'h9999; tick(3);
        chk("done_ss_held", ss_value, 32'h0000002A);

        // done stays high across a new start: no completion, extra press ignored
        sp0 = sp_count;
        btn_raw = 1'b1; tick(20);
        btn_raw = 1'b0; tick(8);
        btn_raw = 1'b1; tick(10);
        btn_raw = 1'b0; tick(10);
        chk("run_busy_held", {31'b0, busy}, 32'd1);
        chk("run_one_start", 32'(sp_count - sp0), 32'd1);
        done = 1'b0; tick(2);
        done = 1'b1; tick(3);
        chk("run_done_again", {31'b0, busy}, 32'd0);

        // auto rotation from page 2
        auto_rotate = 1'b1; tick(1);
        chk("rot_p2_a", {30'b0, page}, 32'd2);
        tick(7);
        chk("rot_p2_b", {30'b0, page}, 32'd2);
        tick(1);
        chk("rot_p3", {30'b0, page}, 32'd3);
        tick(8);
        chk("rot_p0", {30'b0, page}, 32'd0);
        tick(8);
        chk("rot_p1", {30'b0, page}, 32'd1);
        swt_1 = 1'b0; swt_0 = 1'b1; auto_rotate = 1'b0; tick(1);
        chk("rot_manual", {30'b0, page}, 32'd1);

        // restart from DONE and overwrite the snapshot
        swt_1 = 1'b1; swt_0 = 1'b0;
        done = 1'b0; tick(2);
        sp0 = sp_count;
        press_btn();
        chk("restart_start", 32'(sp_count - sp0), 32'd1);
        reg_a0 = 32'h0000BEEF; tick(2);
        done = 1'b1; tick(3);
        chk("overwrite_ss", ss_value, 32'h0000BEEF);
        reg_a0 = 32'h1; tick(3);
        chk("overwrite_held", ss_value, 32'h0000BEEF);

        // randomized traffic
        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 2) == 0) btn_raw = ~btn_raw;
            if ($urandom_range(0, 3) == 0) done = ~done;
            if ($urandom_range(0, 9) == 0) auto_rotate = ~auto_rotate;
            swt_0 = 1'($urandom_range(0, 1));
            swt_1 = 1'($urandom_range(0, 1));
            parameters = $urandom; reg_a0 = $urandom;
            filter_clk_counter = $urandom; clk_counter = $urandom;
            tick($urandom_range(1, 10));
        end

        // async reset in the middle of a run
        btn_raw = 1'b0; done = 1'b0; auto_rotate = 1'b0; tick(20);
        press_btn();
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", {31'b0, busy}, 32'd0);
        chk("async_page", {30'b0, page}, 32'd0);
        chk("async_ss", ss_value, 32'd0);
        tick(3);
        rst = 1'b0;
        sp0 = sp_count;
        tick(20);
        chk("no_start_after_reset", 32'(sp_count - sp0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
